pcm_bank_router: RTL

- Parametrised successor to the fixed three-bank PCM decode in the sound subsystem.
- Maps one wide sample-ROM request stream (YMZ-class PCM chip) onto NBANK SDRAM slot ports, each BANK_AW bits deep.
- Registered request/ack FSM, one-entry read cache, out-of-range fill and per-access timeout.
- Sits between the PCM chip's rom rd/addr/dout/valid interface and the SDRAM slot CS/ADDR/OK/DOUT ports.

---
 rtl/pcm_bank_router.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pcm_bank_router.sv
// pcm_bank_router: maps one PCM sample-ROM request stream onto NBANK SDRAM
// slot ports. It has a registered request/ack FSM, a one-entry read cache,
// a FILL response for out-of-range addresses and a per-access timeout.
module pcm_bank_router #(
  parameter int unsigned    NBANK   = 3,
  parameter int unsigned    BANK_AW = 22,
  parameter int unsigned    AW      = 24,
  parameter int unsigned    DW      = 8,
  parameter int unsigned    TMO     = 255,
  parameter logic [DW-1:0]  FILL    = '0
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     REQ,
  input  logic [AW-1:0]            ADDR,
  input  logic                     FLUSH,
  output logic [DW-1:0]            DOUT,
  output logic                     VALID,
  output logic                     BUSY,
  output logic                     TMO_ERR,
  output logic [NBANK-1:0]         BANK_CS,
  output logic [NBANK*BANK_AW-1:0] BANK_ADDR,
  input  logic [NBANK-1:0]         BANK_OK,
  input  logic [NBANK*DW-1:0]      BANK_DOUT
);

  localparam int unsigned SW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned CW = $clog2(TMO + 1);
  // First address that falls beyond the last bank.
  localparam logic [AW:0] LIMIT = (AW+1)'(NBANK) << BANK_AW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_d;

  // Latched access context and the one-entry cache.
  logic [SW-1:0]  bank_q, bank_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           flushed, flushed_d;
  logic           cache_vld, cache_vld_d;
  logic [AW-1:0]  cache_addr, cache_addr_d;
  logic [DW-1:0]  cache_data, cache_data_d;

  // Next values of the registered outputs.
  logic [DW-1:0]            dout_d;
  logic                     valid_d;
  logic                     busy_d;
  logic                     tmo_err_d;
  logic [NBANK-1:0]         cs_d;
  logic [NBANK*BANK_AW-1:0] bank_addr_d;

  // Request decode.
  logic [SW-1:0]      req_bank;
  logic [BANK_AW-1:0] req_off;
  logic               req_oor;
  logic               req_hit;

  assign req_bank = SW'(ADDR >> BANK_AW);
  assign req_off  = ADDR[BANK_AW-1:0];
  assign req_oor  = {1'b0, ADDR} >= LIMIT;
  assign req_hit  = cache_vld && (ADDR == cache_addr) && !FLUSH;

  // Response of the bank owning the pending access; other banks are ignored.
  logic          sel_ok;
  logic [DW-1:0] sel_dout;

  // Pick OK/data of the latched bank.
  always_comb begin
    sel_ok   = 1'b0;
    sel_dout = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      if (bank_q == SW'(i)) begin
        sel_ok   = BANK_OK[i];
        sel_dout = BANK_DOUT[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    bank_d       = bank_q;
    addr_d       = addr_q;
    cnt_d        = cnt;
    flushed_d    = flushed;
    cache_vld_d  = cache_vld;
    cache_addr_d = cache_addr;
    cache_data_d = cache_data;
    dout_d       = DOUT;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    tmo_err_d    = 1'b0;
    cs_d         = BANK_CS;
    bank_addr_d  = BANK_ADDR;

    if (FLUSH) begin
      cache_vld_d = 1'b0;
    end

    case (state)
      S_IDLE: begin
        cs_d = '0;
        if (REQ) begin
          if (req_hit) begin
            valid_d = 1'b1;
            dout_d  = cache_data;
          end else if (req_oor) begin
            valid_d = 1'b1;
            dout_d  = FILL;
          end else begin
            bank_d    = req_bank;
            addr_d    = ADDR;
            cnt_d     = '0;
            flushed_d = 1'b0;
            cs_d      = NBANK'(1) << req_bank;
            busy_d    = 1'b1;
            state_d   = S_WAIT;
            for (int unsigned i = 0; i < NBANK; i++) begin
              if (req_bank == SW'(i)) begin
                bank_addr_d[i*BANK_AW +: BANK_AW] = req_off;
              end
            end
          end
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (FLUSH) begin
          flushed_d = 1'b1;
        end
        if (sel_ok) begin
          valid_d = 1'b1;
          dout_d  = sel_dout;
          cs_d    = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (!flushed && !FLUSH) begin
            cache_vld_d  = 1'b1;
            cache_addr_d = addr_q;
            cache_data_d = sel_dout;
          end
        end else if (cnt == CW'(TMO - 1)) begin
          valid_d   = 1'b1;
          tmo_err_d = 1'b1;
          dout_d    = FILL;
          cs_d      = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = '0;
      end
    endcase
  end

  // State, context and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      flushed    <= 1'b0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
      DOUT       <= '0;
      VALID      <= 1'b0;
      BUSY       <= 1'b0;
      TMO_ERR    <= 1'b0;
      BANK_CS    <= '0;
      BANK_ADDR  <= '0;
    end else begin
      state      <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      cnt        <= cnt_d;
      flushed    <= flushed_d;
      cache_vld  <= cache_vld_d;
      cache_addr <= cache_addr_d;
      cache_data <= cache_data_d;
      DOUT       <= dout_d;
      VALID      <= valid_d;
      BUSY       <= busy_d;
      TMO_ERR    <= tmo_err_d;
      BANK_CS    <= cs_d;
      BANK_ADDR  <= bank_addr_d;
    end
  end

endmodule
